// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage 64-bit pipeline.
// Resolves branches, runs data-memory accesses over a req/ready handshake
// (stalling upstream while one is outstanding) and owns the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (traps loads/stores whose
// address is not 8-byte aligned instead of sending them to memory).
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_MEM,
    input  logic        Branch_MEM,
    input  logic        Uncondbranch_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic        Mem2Reg_MEM,
    input  logic        ALUzero_MEM,
    input  logic [4:0]  RD_MEM,
    input  logic [63:0] RegOutB_MEM,
    input  logic [63:0] ALUout_MEM,
    input  logic [63:0] PCtarget_MEM,
    input  logic        dmem_ready,
    input  logic [63:0] dmem_rdata,
    output logic        PCSrc,
    output logic [63:0] PCtarget,
    output logic        stall_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic        RegWrite_WB,
    output logic        Mem2Reg_WB,
    output logic [4:0]  RD_WB,
    output logic [63:0] ALUout_WB,
    output logic [63:0] MemData_WB,
    output logic [63:0] memtoregout_WB,
    output logic        mem_err,
    output logic        misalign_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Last WAIT cycle index before the access is abandoned.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [63:0] rbuf_q, rbuf_d;
    logic        regwrite_wb_q, regwrite_wb_d;
    logic        mem2reg_wb_q, mem2reg_wb_d;
    logic [4:0]  rd_wb_q, rd_wb_d;
    logic [63:0] aluout_wb_q, aluout_wb_d;
    logic [63:0] memdata_wb_q, memdata_wb_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
`endif

    logic memop;
    logic req_c, stall_c, fault_c, wb_kill;

    assign memop = MemRead_MEM | MemWrite_MEM;

`ifdef MEM_MISALIGN_TRAP_EN
    // A trapped access must not write the register file when it retires.
    assign wb_kill = mis_q;
`else
    assign wb_kill = 1'b0;
`endif

    // Next-state, handshake outputs and MEM/WB load values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_err_d    = mem_err_q;
        rbuf_d       = rbuf_q;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d        = mis_q;
`endif
        req_c        = 1'b0;
        stall_c      = 1'b0;
        fault_c      = 1'b0;
        // Default MEM/WB load is a bubble.
        regwrite_wb_d = 1'b0;
        mem2reg_wb_d  = 1'b0;
        rd_wb_d       = 5'd0;
        aluout_wb_d   = 64'd0;
        memdata_wb_d  = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (memop) begin
                    stall_c = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                    if (ALUout_MEM[2:0] != 3'b000) begin
                        fault_c = 1'b1;
                        rbuf_d  = 64'd0;
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        req_c   = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = S_WAIT;
                    end
`else
                    req_c   = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = S_WAIT;
`endif
                end else begin
                    regwrite_wb_d = RegWrite_MEM;
                    mem2reg_wb_d  = Mem2Reg_MEM;
                    rd_wb_d       = RD_MEM;
                    aluout_wb_d   = ALUout_MEM;
                end
            end
            S_WAIT: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dmem_ready) begin
                    rbuf_d  = MemWrite_MEM ? 64'd0 : dmem_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_err_d = 1'b1;
                    rbuf_d    = 64'd0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                regwrite_wb_d = RegWrite_MEM & ~wb_kill;
                mem2reg_wb_d  = Mem2Reg_MEM;
                rd_wb_d       = RD_MEM;
                aluout_wb_d   = ALUout_MEM;
                memdata_wb_d  = rbuf_q;
`ifdef MEM_MISALIGN_TRAP_EN
                mis_d         = 1'b0;
`endif
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and MEM/WB register; reset returns everything to idle/zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 16'd0;
            mem_err_q     <= 1'b0;
            rbuf_q        <= 64'd0;
            regwrite_wb_q <= 1'b0;
            mem2reg_wb_q  <= 1'b0;
            rd_wb_q       <= 5'd0;
            aluout_wb_q   <= 64'd0;
            memdata_wb_q  <= 64'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_err_q     <= mem_err_d;
            rbuf_q        <= rbuf_d;
            regwrite_wb_q <= regwrite_wb_d;
            mem2reg_wb_q  <= mem2reg_wb_d;
            rd_wb_q       <= rd_wb_d;
            aluout_wb_q   <= aluout_wb_d;
            memdata_wb_q  <= memdata_wb_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q         <= mis_d;
`endif
        end
    end

    // Handshake/flush outputs are held low while reset is asserted so
    // nothing escapes from a stage that is being cleared.
    assign stall_MEM      = stall_c & ~reset;
    assign dmem_req       = req_c & ~reset;
    assign dmem_we        = req_c & ~reset & MemWrite_MEM;
    assign misalign_fault = fault_c & ~reset;
    assign PCSrc          = (Uncondbranch_MEM | (Branch_MEM & ALUzero_MEM)) & ~stall_c & ~reset;
    assign PCtarget       = PCtarget_MEM;
    assign dmem_addr      = ALUout_MEM;
    assign dmem_wdata     = RegOutB_MEM;
    assign mem_err        = mem_err_q;
    assign RegWrite_WB    = regwrite_wb_q;
    assign Mem2Reg_WB     = mem2reg_wb_q;
    assign RD_WB          = rd_wb_q;
    assign ALUout_WB      = aluout_wb_q;
    assign MemData_WB     = memdata_wb_q;
    assign memtoregout_WB = mem2reg_wb_q ? memdata_wb_q : aluout_wb_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipelined 64-bit processor, directly downstream of the execute stage.
- Consumes the EX/MEM pipeline values and resolves branches (PC select and target back to fetch).
- Performs data-memory loads/stores over a request/ready handshake, stalling upstream while an access is outstanding.
- Owns the MEM/WB pipeline register and drives the WB values used by the forwarding unit.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in WAIT before the access is aborted (1..65535)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state
RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM  in  1 each  EX/MEM control
ALUzero_MEM  in  1  ALU zero flag
RD_MEM  in  5  destination register
RegOutB_MEM  in  64  store data
ALUout_MEM  in  64  ALU result / memory address
PCtarget_MEM  in  64  branch target
dmem_ready  in  1  memory has completed the access (read data valid)
dmem_rdata  in  64  load data
PCSrc  out  1  take branch; also flush for IF/ID and ID/EX
PCtarget  out  64  = PCtarget_MEM
stall_MEM  out  1  upstream stages and PC hold
dmem_req, dmem_we  out  1 each  access request / write enable
dmem_addr, dmem_wdata  out  64 each  = ALUout_MEM / RegOutB_MEM
RegWrite_WB, Mem2Reg_WB  out  1 each  MEM/WB control
RD_WB  out  5  MEM/WB destination
ALUout_WB, MemData_WB  out  64 each  MEM/WB data
memtoregout_WB  out  64  = Mem2Reg_WB ? MemData_WB : ALUout_WB
mem_err  out  1  sticky; set on timeout
misalign_fault  out  1  see Optional Feature

Behaviour:
- memop = MemRead_MEM | MemWrite_MEM.
- If both MemRead_MEM and MemWrite_MEM are high, the access is treated as a store.
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE, memop=0:
  - stall_MEM=0, dmem_req=0.
  - MEM/WB loads RegWrite, Mem2Reg, RD and ALUout each cycle; MemData_WB loads 0.
- IDLE, memop=1:
  - dmem_req=1, dmem_we=MemWrite_MEM, stall_MEM=1.
  - Next state WAIT; timeout counter cleared.
- WAIT:
  - dmem_req=1, stall_MEM=1; address, data and we held stable.
  - dmem_ready=1: capture dmem_rdata into the read buffer (stores capture 0); next state DONE.
  - dmem_ready=0: counter+1. When counter reaches TIMEOUT_CYCLES-1 with no ready: mem_err<=1, read buffer<=0, next state DONE.
  - dmem_ready is sampled only in WAIT; ready seen in IDLE or DONE is ignored.
- DONE:
  - dmem_req=0, stall_MEM=0.
  - MEM/WB loads control/RD/ALUout, and MemData_WB loads the read buffer.
  - Next state IDLE.
- Minimum memory-op occupancy: 3 cycles (IDLE, WAIT, DONE). Each extra cycle without ready adds one cycle.
- While stall_MEM=1, MEM/WB loads a bubble: RegWrite_WB=0, RD_WB=0, all other MEM/WB fields 0.
- Upstream must hold the EX/MEM inputs constant while stall_MEM=1.
- PCSrc = (Uncondbranch_MEM | (Branch_MEM & ALUzero_MEM)) & ~stall_MEM. Combinational, same cycle.
- Reset (including mid-WAIT):
  - Next edge: state IDLE, counter 0, mem_err 0, all MEM/WB fields 0.
  - dmem_req, stall_MEM and PCSrc are low from the first cycle after reset is sampled.
- mem_err is cleared only by reset.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: in IDLE, memop=1 with ALUout_MEM[2:0]!=0:
  - No request is issued (dmem_req stays 0).
  - misalign_fault=1 for that cycle, stall_MEM=1, next state DONE (2-cycle occupancy).
  - In DONE, MEM/WB loads RegWrite_WB=0, so no register writeback occurs.
- Undefined: misalign_fault tied to 0; unaligned addresses are passed to memory unchanged.

Test Plan:
1. ADD-type, RegWrite=1, RD=5, ALUout=0x2A, no memop -> next edge RegWrite_WB=1, RD_WB=5, memtoregout_WB=0x2A; stall_MEM=0 throughout.
2. Load, ALUout=0x100, ready asserted 2 cycles after entering WAIT, rdata=0xDEADBEEF -> dmem_req high 3 cycles, stall_MEM high 3 cycles, bubble (RegWrite_WB=0) during stall, then memtoregout_WB=0xDEADBEEF, RD_WB valid.
3. Store, ALUout=0x80, RegOutB=0x1234, ready in first WAIT cycle -> dmem_we=1, dmem_wdata=0x1234 stable until ready; 3-cycle occupancy; RegWrite_WB follows the input (0).
4. CBZ with Branch=1, ALUzero=1, PCtarget_MEM=0x40 -> PCSrc=1, PCtarget=0x40 same cycle. Repeat with ALUzero=0 -> PCSrc=0. Uncondbranch=1 -> PCSrc=1.
5. Load with ready never asserted, TIMEOUT_CYCLES=4 -> exactly 4 WAIT cycles, then mem_err=1 and MemData_WB=0; mem_err stays 1 until reset.
6. Reset asserted in the 2nd WAIT cycle -> next cycle state IDLE, dmem_req=0, stall_MEM=0, all WB outputs 0. With MEM_MISALIGN_TRAP_EN, load at ALUout=0x103 -> misalign_fault=1, no dmem_req, RegWrite_WB=0.
